// File: rtl/node_position_streamer.sv
// rtl/node_position_streamer.sv - snapshot node x/y positions and stream them one node per beat
module node_position_streamer #(
  parameter int NODES  = 5,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    snap_req,
  input  logic [NODES*DATA_W-1:0] x_flat,
  input  logic [NODES*DATA_W-1:0] y_flat,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic [DATA_W-1:0]       out_x,
  output logic [DATA_W-1:0]       out_y,
  output logic                    out_last,
  output logic [15:0]             frame_count,
  output logic [7:0]              overrun_count
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [DATA_W-1:0] shadow_x [NODES];
  logic [DATA_W-1:0] shadow_y [NODES];
  logic [DATA_W-1:0] sel_x;
  logic [DATA_W-1:0] sel_y;
  logic              at_last;
  logic              xfer;
  logic              last_xfer;
  logic              capture;
  logic              overrun;

  // A snapshot is accepted from IDLE or on the final beat of a frame (back-to-back).
  always_comb begin
    at_last    = (idx == LAST_IDX);
    xfer       = (state == STREAM) && out_ready;
    last_xfer  = xfer && at_last;
    capture    = snap_req && ((state == IDLE) || last_xfer);
    overrun    = snap_req && (state == STREAM) && !last_xfer;
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (snap_req) begin
          state_next = STREAM;
          idx_next   = '0;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          idx_next   = '0;
          state_next = snap_req ? STREAM : IDLE;
        end else if (xfer) begin
          idx_next = idx + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NODES; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NODES; i++) begin
        shadow_x[i] <= x_flat[i*DATA_W +: DATA_W];
        shadow_y[i] <= y_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      if (last_xfer) begin
        frame_count <= frame_count + 16'd1;
      end
      if (overrun && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NODES; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_x = shadow_x[i];
        sel_y = shadow_y[i];
      end
    end
  end

  // Data and last are gated by valid so IDLE never presents a stale beat.
  assign busy      = (state == STREAM);
  assign out_valid = (state == STREAM);
  assign out_idx   = idx;
  assign out_x     = out_valid ? sel_x : '0;
  assign out_y     = out_valid ? sel_y : '0;
  assign out_last  = out_valid && at_last;

endmodule

// File: tb/tb_node_position_streamer.sv
// tb/tb_node_position_streamer.sv - scoreboard bench for node_position_streamer
module tb_node_position_streamer;

  localparam int NODES  = 5;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              last;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    snap_req = 1'b0;
  logic                    out_ready = 1'b0;
  logic [NODES*DATA_W-1:0] x_flat = '0;
  logic [NODES*DATA_W-1:0] y_flat = '0;
  logic                    busy;
  logic                    out_valid;
  logic [IDX_W-1:0]        out_idx;
  logic [DATA_W-1:0]       out_x;
  logic [DATA_W-1:0]       out_y;
  logic                    out_last;
  logic [15:0]             frame_count;
  logic [7:0]              overrun_count;

  int          vectors = 0;
  int          miscompares = 0;
  beat_t       q[$];
  logic        m_busy = 1'b0;
  logic [15:0] m_frames = '0;
  logic [7:0]  m_ovr = '0;

  node_position_streamer #(.NODES(NODES), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .snap_req(snap_req), .x_flat(x_flat), .y_flat(y_flat),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_x(out_x), .out_y(out_y), .out_last(out_last), .frame_count(frame_count),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [DATA_W-1:0] xb, input logic [DATA_W-1:0] yb);
    for (int i = 0; i < NODES; i++) begin
      x_flat[i*DATA_W +: DATA_W] = xb + DATA_W'(i);
      y_flat[i*DATA_W +: DATA_W] = yb + DATA_W'(i);
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NODES; i++) begin
      x_flat[i*DATA_W +: DATA_W] = $urandom;
      y_flat[i*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  // Called at a falling edge with inputs settled: compare outputs, then advance the model across the next rising edge.
  task automatic tick();
    logic  xfer;
    logic  last_xfer;
    logic  cap;
    beat_t b;
    check_val("valid", {63'd0, out_valid}, {63'd0, m_busy});
    check_val("busy", {63'd0, busy}, {63'd0, m_busy});
    check_val("frames", {48'd0, frame_count}, {48'd0, m_frames});
    check_val("overrun", {56'd0, overrun_count}, {56'd0, m_ovr});
    if (m_busy && q.size() > 0) begin
      check_val("idx", {56'd0, out_idx}, {56'd0, q[0].idx});
      check_val("x", {32'd0, out_x}, {32'd0, q[0].x});
      check_val("y", {32'd0, out_y}, {32'd0, q[0].y});
      check_val("last", {63'd0, out_last}, {63'd0, q[0].last});
    end
    xfer      = m_busy && out_ready;
    last_xfer = xfer && (q.size() == 1);
    if (xfer) void'(q.pop_front());
    if (last_xfer) m_frames = m_frames + 16'd1;
    if (m_busy && snap_req && !last_xfer && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
    cap = snap_req && (!m_busy || last_xfer);
    if (cap) begin
      for (int i = 0; i < NODES; i++) begin
        b.idx  = IDX_W'(i);
        b.x    = x_flat[i*DATA_W +: DATA_W];
        b.y    = y_flat[i*DATA_W +: DATA_W];
        b.last = (i == NODES - 1);
        q.push_back(b);
      end
    end
    m_busy = cap || (m_busy && !last_xfer);
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (m_busy && n < max_cycles) begin
      tick();
      n++;
    end
    check_val("drain_done", {63'd0, m_busy}, 64'd0);
  endtask

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_x", {32'd0, out_x}, 64'd0);
    check_val("rst_frames", {48'd0, frame_count}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // basic frame
    set_data(32'h100, 32'h200);
    out_ready = 1'b1;
    snap_req  = 1'b1;
    tick();
    snap_req = 1'b0;
    drain(20);
    check_val("t1_frames", {48'd0, frame_count}, 64'd1);
    check_val("t1_busy", {63'd0, busy}, 64'd0);

    // stalled readout with 1,0,0 ready pattern
    randomize_data();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    n = 0;
    while (m_busy && n < 40) begin
      out_ready = (n % 3 == 0);
      tick();
      n++;
    end
    check_val("t2_done", {63'd0, m_busy}, 64'd0);

    // inputs churn during stream
    randomize_data();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    n = 0;
    while (m_busy && n < 60) begin
      randomize_data();
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check_val("t3_done", {63'd0, m_busy}, 64'd0);

    // back-to-back frame via snap on last beat
    out_ready = 1'b1;
    set_data(32'h300, 32'h400);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    n = 0;
    while (q.size() > 1 && n < 20) begin
      tick();
      n++;
    end
    set_data(32'h500, 32'h600);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check_val("t5_valid", {63'd0, out_valid}, 64'd1);
    check_val("t5_idx", {56'd0, out_idx}, 64'd0);
    check_val("t5_x", {32'd0, out_x}, 64'h500);
    drain(20);
    check_val("t5_frames", {48'd0, frame_count}, 64'd5);

    // overruns while stalled mid-frame
    set_data(32'h700, 32'h800);
    snap_req = 1'b1;
    tick();
    snap_req  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    randomize_data();
    snap_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    snap_req = 1'b0;
    tick();
    check_val("t4_ovr3", {56'd0, overrun_count}, 64'd3);
    snap_req = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    snap_req = 1'b0;
    tick();
    check_val("t4_ovr_sat", {56'd0, overrun_count}, 64'hFF);
    out_ready = 1'b1;
    drain(20);

    // async reset at idx 2
    set_data(32'h900, 32'hA00);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
    tick();
    check_val("t6_idx2", {56'd0, out_idx}, 64'd2);
    #2 reset = 1'b0;
    #1;
    check_val("t6_valid", {63'd0, out_valid}, 64'd0);
    check_val("t6_busy", {63'd0, busy}, 64'd0);
    check_val("t6_idx", {56'd0, out_idx}, 64'd0);
    check_val("t6_x", {32'd0, out_x}, 64'd0);
    check_val("t6_y", {32'd0, out_y}, 64'd0);
    check_val("t6_last", {63'd0, out_last}, 64'd0);
    check_val("t6_frames", {48'd0, frame_count}, 64'd0);
    check_val("t6_ovr", {56'd0, overrun_count}, 64'd0);
    q.delete();
    m_busy   = 1'b0;
    m_frames = '0;
    m_ovr    = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_data(32'hB00, 32'hC00);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check_val("t6_restart_idx", {56'd0, out_idx}, 64'd0);
    drain(20);
    check_val("t6_frames_after", {48'd0, frame_count}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
